// File: rtl/sub_pipe_pkg.sv
// Shared types and defaults for the sub1->sub2 request sequencer.
package sub_pipe_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int LAT_DEF     = 2;
  localparam int CNT_W       = 4;

  typedef logic [2:0][7:0] byte3_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic       a;
    logic [1:0] b;
    byte3_t     c;
    byte3_t     d;
  } operand_t;

  typedef struct packed {
    logic       i;
    logic [1:0] j;
    byte3_t     k;
    byte3_t     l;
  } result_t;

endpackage

// File: rtl/sub_pipe_if.sv
// Requester, datapath and response signals of sub_pipe_seq.
interface sub_pipe_if
  import sub_pipe_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_a;
  logic [NUM_REQ-1:0][1:0] req_b;
  byte3_t [NUM_REQ-1:0]    req_c;
  byte3_t [NUM_REQ-1:0]    req_d;

  logic                    sig_a;
  logic [1:0]              sig_b;
  byte3_t                  sig_c;
  byte3_t                  sig_d;
  logic                    dp_start;

  logic                    sig_i;
  logic [1:0]              sig_j;
  byte3_t                  sig_k;
  byte3_t                  sig_l;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_i;
  logic [1:0]              rsp_j;
  byte3_t                  rsp_k;
  byte3_t                  rsp_l;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, req_c, req_d,
    output sig_i, sig_j, sig_k, sig_l,
    output rsp_ready,
    input  req_ready, sig_a, sig_b, sig_c, sig_d, dp_start,
    input  rsp_valid, rsp_id, rsp_i, rsp_j, rsp_k, rsp_l, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d,
    input  sig_i, sig_j, sig_k, sig_l,
    input  rsp_ready,
    output req_ready, sig_a, sig_b, sig_c, sig_d, dp_start,
    output rsp_valid, rsp_id, rsp_i, rsp_j, rsp_k, rsp_l, busy
  );

endinterface

// File: rtl/sub_pipe_seq_rr_arb.sv
// Round-robin arbiter: the requester after the last grantee gets first priority.
module rr_arb
  import sub_pipe_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % 32'(N));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sub_pipe_seq.sv
// Shares one fixed-latency sub1->sub2 datapath between NUM_REQ requesters,
// one operation at a time: accept, launch, wait LAT cycles, hold the response.
module sub_pipe_seq
  import sub_pipe_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LAT     = LAT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  sub_pipe_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    owner;
  logic               accept;
  logic               dp_start_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  operand_t           sel_ops;
  operand_t           ops;
  result_t            rsp;

  rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .idx     (grant_idx)
  );

  // The arbiter is combinational, so gate with rst_n to keep the strobe low during reset.
  assign bus.req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign accept        = |bus.req_ready;

  always_comb begin
    sel_ops   = '0;
    sel_ops.a = bus.req_a[grant_idx];
    sel_ops.b = bus.req_b[grant_idx];
    sel_ops.c = bus.req_c[grant_idx];
    sel_ops.d = bus.req_d[grant_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ops         <= '0;
      owner       <= '0;
      dp_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp         <= '0;
    end else begin
      dp_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ops        <= sel_ops;
            owner      <= grant_idx;
            dp_start_q <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_W'(LAT);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A count of 1 here is exactly LAT cycles after the dp_start cycle.
          if (cnt == CNT_W'(1)) begin
            rsp         <= '{i: bus.sig_i, j: bus.sig_j, k: bus.sig_k, l: bus.sig_l};
            rsp_id_q    <= owner;
            rsp_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sig_a     = ops.a;
  assign bus.sig_b     = ops.b;
  assign bus.sig_c     = ops.c;
  assign bus.sig_d     = ops.d;
  assign bus.dp_start  = dp_start_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_i     = rsp.i;
  assign bus.rsp_j     = rsp.j;
  assign bus.rsp_k     = rsp.k;
  assign bus.rsp_l     = rsp.l;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sub_pipe_seq.sv
// Self-checking bench for sub_pipe_seq: transaction table, directed corner cases, random traffic.
module tb_sub_pipe_seq;
  import sub_pipe_pkg::*;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub_pipe_if #(.NUM_REQ(N)) bus ();
  sub_pipe_if #(.NUM_REQ(N)) bus1 ();
  sub_pipe_if #(.NUM_REQ(N)) bus15 ();

  sub_pipe_seq #(.NUM_REQ(N), .LAT(LAT)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  sub_pipe_seq #(.NUM_REQ(N), .LAT(1))   dut_l1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sub_pipe_seq #(.NUM_REQ(N), .LAT(15))  dut_l15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

  typedef struct {
    logic [N-1:0] valid;
    int           stall;
    int           exp_id;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [N-1:0] v_valid;
  logic         v_rsp_ready;
  operand_t     v_ops [N];
  result_t      v_res;
  logic [N-1:0] last_rdy;
  int           n_grant1;

  // Reference model: one transaction in flight, timed from its accept cycle.
  bit       m_active;
  int       m_t;
  int       m_ptr;
  int       m_owner;
  operand_t m_ops;
  result_t  m_rsp;
  int       m_rsp_id;
  int       cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic operand_t rand_ops();
    operand_t r;
    r.a = 1'($urandom);
    r.b = 2'($urandom);
    r.c = 24'($urandom);
    r.d = 24'($urandom);
    return r;
  endfunction

  function automatic result_t rand_res();
    result_t r;
    r.i = 1'($urandom);
    r.j = 2'($urandom);
    r.k = 24'($urandom);
    r.l = 24'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr    = 0;
    m_ops    = '0;
    m_rsp    = '0;
    m_rsp_id = 0;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, '0);
    chk({tag, "_sig"}, {bus.sig_a, bus.sig_b, bus.sig_c, bus.sig_d}, '0);
    chk({tag, "_ctl"}, {bus.dp_start, bus.rsp_valid, bus.busy}, '0);
    chk({tag, "_rsp_id"}, bus.rsp_id, '0);
    chk({tag, "_rsp"}, {bus.rsp_i, bus.rsp_j, bus.rsp_k, bus.rsp_l}, '0);
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    logic         exp_rv;
    bus.req_valid = v_valid;
    bus.rsp_ready = v_rsp_ready;
    bus.req_a     = {v_ops[1].a, v_ops[0].a};
    bus.req_b     = {v_ops[1].b, v_ops[0].b};
    bus.req_c     = {v_ops[1].c, v_ops[0].c};
    bus.req_d     = {v_ops[1].d, v_ops[0].d};
    v_res         = rand_res();
    bus.sig_i     = v_res.i;
    bus.sig_j     = v_res.j;
    bus.sig_k     = v_res.k;
    bus.sig_l     = v_res.l;
    #1;
    g = -1;
    if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && ((v_valid >> c) & 1) != 0) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    exp_rv  = m_active && (cyc >= m_t + 2 + LAT);
    last_rdy = bus.req_ready;
    if (bus.req_ready[1]) n_grant1++;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("busy", bus.busy, m_active);
    chk("dp_start", bus.dp_start, m_active && (cyc == m_t + 1));
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    chk("sig_ops", {bus.sig_a, bus.sig_b, bus.sig_c, bus.sig_d}, m_ops);
    chk("rsp_data", {bus.rsp_i, bus.rsp_j, bus.rsp_k, bus.rsp_l}, m_rsp);
    chk("rsp_id", bus.rsp_id, m_rsp_id);
    if (m_active && cyc == m_t + 1 + LAT) begin
      m_rsp    = v_res;
      m_rsp_id = m_owner;
    end
    if (exp_rv && v_rsp_ready) begin
      m_active = 1'b0;
    end else if (!m_active && g >= 0) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_owner  = g;
      m_ops    = (g == 1) ? v_ops[1] : v_ops[0];
      m_ptr    = (g + 1) % N;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Runs until one response handshake, holding rsp_ready low for `stall` RESP cycles.
  task automatic run_txn(input int stall, output bit done, output int got_id);
    done   = 1'b0;
    got_id = -1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (m_active && cyc >= m_t + 2 + LAT) begin
        if (stall > 0) begin
          v_rsp_ready = 1'b0;
          stall--;
        end else begin
          v_rsp_ready = 1'b1;
          done        = 1'b1;
          got_id      = int'(bus.rsp_id);
        end
      end else begin
        v_rsp_ready = 1'($urandom);
      end
      step();
    end
  endtask

  task automatic lat_test();
    int  t_dp1 = -1, t_rv1 = -1, t_dp15 = -1, t_rv15 = -1;
    bit  drop1 = 1'b0, drop15 = 1'b0;
    bus1.req_valid  = 2'b01;
    bus15.req_valid = 2'b01;
    bus1.rsp_ready  = 1'b1;
    bus15.rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (drop1) bus1.req_valid = '0;
      if (drop15) bus15.req_valid = '0;
      #1;
      if (bus1.req_ready[0]) drop1 = 1'b1;
      if (bus15.req_ready[0]) drop15 = 1'b1;
      if (bus1.dp_start && t_dp1 < 0) t_dp1 = c;
      if (bus1.rsp_valid && t_rv1 < 0) t_rv1 = c;
      if (bus15.dp_start && t_dp15 < 0) t_dp15 = c;
      if (bus15.rsp_valid && t_rv15 < 0) t_rv15 = c;
      @(posedge clk);
      #1;
    end
    chk("lat1_seen", {t_dp1 >= 0, t_rv1 >= 0}, 2'b11);
    chk("lat1_dp_to_rsp", t_rv1 - t_dp1, 2);
    chk("lat15_seen", {t_dp15 >= 0, t_rv15 >= 0}, 2'b11);
    chk("lat15_dp_to_rsp", t_rv15 - t_dp15, 16);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    bit   done;
    int   got;
    int   g1_before;

    vecs[0] = '{2'b01, 0, 0};
    vecs[1] = '{2'b11, 0, 1};
    vecs[2] = '{2'b11, 0, 0};
    vecs[3] = '{2'b11, 0, 1};
    vecs[4] = '{2'b11, 0, 0};
    vecs[5] = '{2'b11, 0, 1};
    vecs[6] = '{2'b11, 5, 0};
    vecs[7] = '{2'b10, 0, 1};
    vecs[8] = '{2'b01, 2, 0};

    v_valid = '0;
    v_rsp_ready = 1'b0;
    v_ops[0] = '0;
    v_ops[1] = '0;
    n_grant1 = 0;
    cyc = 0;
    m_t = 0;
    m_owner = 0;
    model_reset();
    bus.req_valid = '0; bus.rsp_ready = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
    bus.sig_i = '0; bus.sig_j = '0; bus.sig_k = '0; bus.sig_l = '0;
    bus1.req_valid = '0; bus1.rsp_ready = 1'b0;
    bus1.req_a = '0; bus1.req_b = '0; bus1.req_c = '0; bus1.req_d = '0;
    bus1.sig_i = '0; bus1.sig_j = '0; bus1.sig_k = '0; bus1.sig_l = '0;
    bus15.req_valid = '0; bus15.rsp_ready = 1'b0;
    bus15.req_a = '0; bus15.req_b = '0; bus15.req_c = '0; bus15.req_d = '0;
    bus15.sig_i = '0; bus15.sig_j = '0; bus15.sig_k = '0; bus15.sig_l = '0;

    repeat (2) @(posedge clk);
    #1;
    check_rst("por");
    rst_n = 1'b1;

    lat_test();

    v_ops[0] = '{a: 1'b1, b: 2'b10, c: 24'h112233, d: 24'h445566};
    v_ops[1] = rand_ops();
    for (int i = 0; i < 9; i++) begin
      v_valid = vecs[i].valid;
      run_txn(vecs[i].stall, done, got);
      chk($sformatf("vec%0d_done", i), done, 1'b1);
      chk($sformatf("vec%0d_id", i), got, vecs[i].exp_id);
      v_ops[0] = rand_ops();
      v_ops[1] = rand_ops();
    end

    // Reset while waiting on the datapath, then only requester 1 asks.
    v_valid = 2'b01;
    v_rsp_ready = 1'b0;
    for (int c = 0; c < 10 && !(m_active && cyc == m_t + 2); c++) step();
    chk("wait_reached_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_rst("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v_valid = 2'b10;
    step();
    chk("post_rst_grant", last_rdy, 2'b10);
    run_txn(0, done, got);
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_id", got, 1);

    // Requester 1 raises and withdraws its request while the block is busy.
    v_valid = 2'b01;
    v_rsp_ready = 1'b0;
    step();
    g1_before = n_grant1;
    v_valid = 2'b11;
    step();
    step();
    v_valid = 2'b01;
    run_txn(0, done, got);
    chk("withdraw_txn1_done", done, 1'b1);
    run_txn(1, done, got);
    chk("withdraw_txn2_id", got, 0);
    chk("withdrawn_never_granted", n_grant1 - g1_before, 0);

    for (int c = 0; c < 400; c++) begin
      v_valid = N'($urandom);
      v_rsp_ready = 1'($urandom);
      if ($urandom_range(3) == 0) begin
        v_ops[0] = rand_ops();
        v_ops[1] = rand_ops();
      end
      step();
    end
    v_valid = '0;
    v_rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) step();
    chk("drained_idle", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_pipe_seq.md
SUB_PIPE_SEQ -- requirements
Module: sub_pipe_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing the sub1->sub2 datapath (range 2..8).
REQ-003 Parameter LAT, default 2, SHALL set the datapath latency in cycles from dp_start to valid sig_i..sig_l (range 1..15).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester request pending.
REQ-007 req_ready  out  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-008 req_a  in  NUM_REQ x 1  per-requester operand a.
REQ-009 req_b  in  NUM_REQ x 2  per-requester operand b.
REQ-010 req_c, req_d  in  NUM_REQ x 3 x 8 each  per-requester operands c and d.
REQ-011 sig_a, sig_b, sig_c, sig_d  out  1 / 2 / 3x8 / 3x8  registered operands to sub1.
REQ-012 dp_start  out  1  one-cycle launch pulse to the datapath.
REQ-013 sig_i, sig_j, sig_k, sig_l  in  1 / 2 / 3x8 / 3x8  results from sub2.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 rsp_id  out  clog2(NUM_REQ)  index of the requester owning the response.
REQ-016 rsp_i, rsp_j, rsp_k, rsp_l  out  1 / 2 / 3x8 / 3x8  captured results.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: if any req_valid is high, the arbiter SHALL grant round-robin, assert req_ready for the grantee for exactly that cycle, latch its operands into sig_a..sig_d and its index, and go to ISSUE.
REQ-020 The round-robin pointer SHALL start at 0 and, after a grant to index k, SHALL give priority to index (k+1) mod NUM_REQ.
REQ-021 ISSUE SHALL last one cycle with dp_start=1, load the latency counter with LAT, and go to WAIT.
REQ-022 WAIT SHALL decrement the counter each cycle; when it reaches 1, sig_i..sig_l SHALL be captured into rsp_* (sampled LAT cycles after dp_start) and the FSM SHALL go to RESP.
REQ-023 RESP SHALL hold rsp_valid=1 with stable rsp_id and rsp_* until rsp_valid && rsp_ready, then go to IDLE.
REQ-024 Latency: accept at cycle T gives dp_start at T+1 and rsp_valid at T+2+LAT; a new grant is possible no earlier than the cycle after the response handshake.
REQ-025 sig_a..sig_d SHALL hold their values from accept until the next accept.
REQ-026 req_ready SHALL be 0 outside IDLE; requests arriving while busy SHALL wait, with no loss and no reordering within a requester.
REQ-027 A request that drops req_valid before it is granted SHALL NOT be granted.
REQ-028 rsp_ready asserted while rsp_valid=0 SHALL be ignored.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, pointer=0, counter=0, and all outputs 0 (req_ready, sig_*, dp_start, rsp_valid, rsp_id, rsp_*, busy).
REQ-030 A reset in any state SHALL abort the operation in flight with no response; the first grant after release SHALL follow REQ-019 with pointer 0.

Structure
REQ-031 Package sub_pipe_pkg SHALL hold the state enum, byte3_t (3x8 packed), the operand and result struct typedefs, and the default constants NUM_REQ_DEF=2 and LAT_DEF=2.
REQ-032 The round-robin arbiter SHALL be a separate sub-module rr_arb (inputs: req, advance; outputs: one-hot grant, index).

Verification
REQ-033 Single request: req_valid=01, a=1, b=2'b10, c={8'h11,8'h22,8'h33}, LAT=2 -> req_ready=01 at T, dp_start at T+1, rsp_valid at T+4 with rsp_id=0 and rsp_* equal to the driven sig_i..sig_l.
REQ-034 Contention: req_valid=11 held through 4 operations with rsp_ready=1 -> grant order 0,1,0,1.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, busy=1, req_ready=0 throughout; handshake on cycle 6 -> IDLE.
REQ-036 Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately, no rsp_valid; with req_valid=10 after release, requester 1 is granted (pointer=0, requester 0 idle).
REQ-037 LAT=1 and LAT=15 builds: rsp_valid exactly LAT+1 cycles after dp_start.
REQ-038 Withdrawn request: requester 1 raises then drops req_valid while busy -> it is never granted.
